// File: rtl/split_seq_pkg.sv
// split_seq_pkg
//   Shared types, sizes and lane-walking helpers for the split_seq byte
//   serializer and its word splitter.
//   Contents:
//     state_t     - controller states (IDLE, SEND)
//     lane_sel_t  - result of a lane search: lane index plus a none-left flag
//     BYTE_W, LANES, LANE_W, WORD_W - fixed datapath geometry
//     next_lane() - next enabled lane after ptr in the given order
//     first_lane() - first enabled lane of a mask in the given order
package split_seq_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;
  localparam int WORD_W = BYTE_W * LANES;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic              none;
    logic [LANE_W-1:0] lane;
  } lane_sel_t;

  // Nearest enabled lane strictly after ptr in emission order.
  // lsb_first=1 walks upward (0->3), otherwise downward (3->0).
  // none=1 means ptr is the last enabled lane of the mask.
  function automatic lane_sel_t next_lane(input logic [LANES-1:0]  mask,
                                          input logic [LANE_W-1:0] ptr,
                                          input logic              lsb_first);
    lane_sel_t sel;
    int        cand;
    sel.none = 1'b1;
    sel.lane = ptr;
    for (int k = 1; k < LANES; k++) begin
      cand = lsb_first ? (int'(ptr) + k) : (int'(ptr) - k);
      // The search stops at the first hit so the nearest lane wins.
      if (sel.none && (cand >= 0) && (cand < LANES) && mask[cand[LANE_W-1:0]]) begin
        sel.none = 1'b0;
        sel.lane = cand[LANE_W-1:0];
      end
    end
    return sel;
  endfunction

  // First enabled lane of a non-zero mask in emission order.
  function automatic logic [LANE_W-1:0] first_lane(input logic [LANES-1:0] mask,
                                                   input logic             lsb_first);
    logic [LANE_W-1:0] start;
    lane_sel_t         sel;
    start = lsb_first ? '0 : LANE_W'(LANES - 1);
    sel   = next_lane(mask, start, lsb_first);
    return mask[start] ? start : sel.lane;
  endfunction

endpackage

// File: rtl/split_seq_splitter.sv
// split_seq_splitter
//   Purely combinational word splitter: breaks a 32-bit word into its four
//   byte lanes, lane i = bits [8i+7:8i].
//   Ports:
//     i_word  in  32     word to split
//     o_bytes out 4x8    byte lanes, o_bytes[i] = lane i
module split_seq_splitter
  import split_seq_pkg::*;
(
  input  logic [WORD_W-1:0]            i_word,
  output logic [LANES-1:0][BYTE_W-1:0] o_bytes
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign o_bytes[gi] = i_word[gi*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/split_seq.sv
// split_seq
//   Byte serializer: accepts a 32-bit word plus 4-bit byte-enable mask over a
//   valid/ready handshake and emits only the enabled lanes, one per handshake,
//   on an 8-bit valid/ready stream, flagging the final byte of each word.
//   Build option: SPLIT_SEQ_LSB_FIRST_EN
//     defined   - lanes emitted 0 -> 3 (LSB byte first)
//     undefined - lanes emitted 3 -> 0 (MSB byte first)
//   Ports:
//     clk        in   1   rising-edge clock
//     reset      in   1   synchronous, active-high
//     in_valid   in   1   producer offers in_word/in_be
//     in_ready   out  1   word can be accepted this cycle
//     in_word    in   32  word to serialize
//     in_be      in   4   byte enables, bit i = lane i
//     out_valid  out  1   out_byte/out_lane/out_last valid
//     out_ready  in   1   consumer takes the current byte
//     out_byte   out  8   selected lane data
//     out_lane   out  2   lane index being emitted
//     out_last   out  1   no further enabled lane for this word
//     busy       out  1   a word is held (SEND)
module split_seq
  import split_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [LANES-1:0]  in_be,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic [LANE_W-1:0] out_lane,
  output logic              out_last,
  output logic              busy
);

`ifdef SPLIT_SEQ_LSB_FIRST_EN
  localparam logic LSB_FIRST = 1'b1;
`else
  localparam logic LSB_FIRST = 1'b0;
`endif

  state_t              r_state, w_state_next;
  logic [WORD_W-1:0]   r_word,  w_word_next;
  logic [LANES-1:0]    r_mask,  w_mask_next;
  logic [LANE_W-1:0]   r_ptr,   w_ptr_next;

  logic [LANES-1:0][BYTE_W-1:0] w_bytes;
  lane_sel_t                    w_adv;
  logic                         w_last;
  logic                         w_fire_out;
  logic                         w_accept;

  split_seq_splitter u_splitter (
    .i_word  (r_word),
    .o_bytes (w_bytes)
  );

  assign w_adv      = next_lane(r_mask, r_ptr, LSB_FIRST);
  assign w_last     = w_adv.none;

  assign out_valid  = (r_state == SEND);
  assign busy       = (r_state == SEND);
  assign out_byte   = w_bytes[r_ptr];
  assign out_lane   = r_ptr;
  // Gated so the flag reads 0 in IDLE, where the mask search is meaningless.
  assign out_last   = out_valid && w_last;

  assign w_fire_out = out_valid && out_ready;
  // Accepting on the final byte's handshake keeps back-to-back words bubble-free.
  assign in_ready   = !reset && ((r_state == IDLE) || (w_fire_out && w_last));
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    w_word_next  = r_word;
    w_mask_next  = r_mask;
    w_ptr_next   = r_ptr;
    if (w_accept) begin
      w_word_next = in_word;
      w_mask_next = in_be;
      if (in_be != '0) begin
        w_state_next = SEND;
        w_ptr_next   = first_lane(in_be, LSB_FIRST);
      end else begin
        // Empty mask: the word is consumed and dropped.
        w_state_next = IDLE;
      end
    end else if (w_fire_out) begin
      if (w_last) begin
        w_state_next = IDLE;
      end else begin
        w_ptr_next = w_adv.lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_mask  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_word  <= w_word_next;
      r_mask  <= w_mask_next;
      r_ptr   <= w_ptr_next;
    end
  end

endmodule

// File: tb/tb_split_seq.sv
// tb_split_seq
//   Directed self-checking bench for split_seq. Expected bytes, lanes and
//   last flags are written out by hand for each scenario; the emission order
//   follows SPLIT_SEQ_LSB_FIRST_EN when the bench is built with it.
module tb_split_seq;

`ifdef SPLIT_SEQ_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [3:0]  in_be;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  split_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_be     (in_be),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane emitted at position k (0 = first) of a full-mask word.
  function automatic logic [1:0] lane_of(input int k);
    return LSB ? 2'(k) : 2'(3 - k);
  endfunction

  // One accept cycle; in_valid drops afterwards.
  task automatic offer(input string tag, input logic [31:0] w, input logic [3:0] be);
    in_valid = 1'b1;
    in_word  = w;
    in_be    = be;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Checks the current byte beat (out_ready assumed 1) then advances a cycle.
  task automatic exp_byte(input string tag, input logic [7:0] b, input logic [1:0] l,
                          input logic last);
    #1;
    $display("beat %s: byte=0x%02h lane=%0d last=%0b", tag, out_byte, out_lane, out_last);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_byte"}, out_byte, b);
    check({tag, "_lane"}, out_lane, l);
    check({tag, "_last"}, out_last, last);
    check({tag, "_in_ready"}, in_ready, last);
    tick();
  endtask

  // Full-mask word: bytes given MSB-first as b3..b0.
  task automatic exp_full(input string tag, input logic [7:0] b3, input logic [7:0] b2,
                          input logic [7:0] b1, input logic [7:0] b0);
    logic [7:0] lanes [4];
    lanes[3] = b3; lanes[2] = b2; lanes[1] = b1; lanes[0] = b0;
    for (int k = 0; k < 4; k++)
      exp_byte($sformatf("%s%0d", tag, k), lanes[lane_of(k)], lane_of(k), k == 3);
  endtask

  task automatic exp_idle(input string tag);
    #1;
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    in_be     = '0;
    out_ready = 1'b1;
    tick();
    tick();
    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_byte", out_byte, 8'h00);
    check("rst_lane", out_lane, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Full mask, one byte per cycle
    offer("s1", 32'h11223344, 4'hF);
    exp_full("s1_b", 8'h11, 8'h22, 8'h33, 8'h44);
    exp_idle("s1_end");

    // Sparse mask 0101: lanes 2 and 0 only
    offer("s2", 32'hAABBCCDD, 4'b0101);
`ifdef SPLIT_SEQ_LSB_FIRST_EN
    exp_byte("s2_b0", 8'hDD, 2'd0, 1'b0);
    exp_byte("s2_b1", 8'hBB, 2'd2, 1'b1);
`else
    exp_byte("s2_b0", 8'hBB, 2'd2, 1'b0);
    exp_byte("s2_b1", 8'hDD, 2'd0, 1'b1);
`endif
    exp_idle("s2_end");

    // Empty mask: dropped, nothing emitted
    offer("s3", 32'h55667788, 4'h0);
    exp_idle("s3_a");
    tick();
    exp_idle("s3_b");

    // Stall on the second byte; a competing word must be ignored
    offer("s4", 32'h11223344, 4'hF);
    exp_byte("s4_b0", (LSB ? 8'h44 : 8'h11), lane_of(0), 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_word   = 32'hDEADBEEF;
    in_be     = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("s4_stall%0d_valid", i), out_valid, 1);
      check($sformatf("s4_stall%0d_byte", i), out_byte, (LSB ? 8'h33 : 8'h22));
      check($sformatf("s4_stall%0d_lane", i), out_lane, lane_of(1));
      check($sformatf("s4_stall%0d_last", i), out_last, 0);
      check($sformatf("s4_stall%0d_in_ready", i), in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    exp_byte("s4_b1", (LSB ? 8'h33 : 8'h22), lane_of(1), 1'b0);
    exp_byte("s4_b2", (LSB ? 8'h22 : 8'h33), lane_of(2), 1'b0);
    exp_byte("s4_b3", (LSB ? 8'h11 : 8'h44), lane_of(3), 1'b1);
    exp_idle("s4_end");

    // Back-to-back full words: the second is taken on the first's last byte
    offer("s5", 32'h01020304, 4'hF);
    in_valid = 1'b1;
    in_word  = 32'h05060708;
    in_be    = 4'hF;
    for (int k = 0; k < 3; k++)
      exp_byte($sformatf("s5_a%0d", k), (LSB ? 8'(4 - k) : 8'(1 + k)), lane_of(k), 1'b0);
    exp_byte("s5_a3", (LSB ? 8'h01 : 8'h04), lane_of(3), 1'b1);
    in_valid = 1'b0;
    exp_full("s5_b", 8'h05, 8'h06, 8'h07, 8'h08);
    exp_idle("s5_end");

    // Reset after the second byte discards the rest
    offer("s6", 32'h11223344, 4'hF);
    exp_byte("s6_b0", (LSB ? 8'h44 : 8'h11), lane_of(0), 1'b0);
    exp_byte("s6_b1", (LSB ? 8'h33 : 8'h22), lane_of(1), 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("s6_rst_valid", out_valid, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_byte", out_byte, 8'h00);
    check("s6_rst_lane", out_lane, 0);
    check("s6_rst_last", out_last, 0);
    check("s6_rst_in_ready", in_ready, 1);
    offer("s6_new", 32'hCAFEBABE, 4'hF);
    exp_full("s6_c", 8'hCA, 8'hFE, 8'hBA, 8'hBE);
    exp_idle("s6_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/split_seq.md
# split_seq

Byte serializer/controller for the 32-bit byte splitter datapath. It accepts one 32-bit word plus a 4-bit byte-enable mask over a valid/ready handshake. It then emits only the enabled byte lanes, one per handshake, on an 8-bit valid/ready stream, and flags the final byte of each word. It sits between a word-wide producer, such as a register or memory read port, and a byte-wide consumer, such as a UART TX or byte bus.

## Interface
Parameters:
- None. Word width is fixed at 32, byte width at 8, lane count at 4. Lane i = bits [8i+7:8i].

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  producer offers in_word/in_be
- in_ready  out  1  block can accept a word this cycle
- in_word  in  32  word to serialize
- in_be  in  4  byte enables, bit i = lane i
- out_valid  out  1  out_byte/out_lane/out_last valid
- out_ready  in  1  consumer accepts the current byte
- out_byte  out  8  selected lane data
- out_lane  out  2  index of lane being emitted
- out_last  out  1  no further enabled lanes remain for this word
- busy  out  1  a word is held (state SEND)

## Operation
- States: IDLE, SEND. Reset → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - register the word and mask.
  - If mask≠0: lane pointer = first enabled lane in emission order; go to SEND.
  - If mask=0: word is consumed and dropped; stay in IDLE; no output.
- SEND: out_valid=1; out_byte = held lane[ptr]; out_lane = ptr; out_last = (no enabled lane after ptr).
- On out_valid&&out_ready with out_last=0: ptr advances to the next enabled lane, skipping disabled lanes in the same cycle.
- On out_valid&&out_ready with out_last=1: go to IDLE, unless a new word is accepted that cycle; in that case load it and stay in SEND (or go to IDLE if its mask=0).
- in_ready = IDLE || (SEND && out_valid && out_ready && out_last). This is a combinational path from out_ready.
- Default emission order is lane 3 → lane 0 (MSB byte first).
- busy = (state==SEND).

## Timing
- Reset values: out_valid=0, out_byte=0x00, out_lane=0, out_last=0, busy=0, held word/mask=0. in_ready=0 while reset is high, 1 the cycle after.
- Latency: word accepted at edge N → first byte has out_valid=1 in cycle N+1.
- Throughput: one byte per cycle with out_ready=1. Back-to-back full-mask words produce continuous out_valid with no bubble.
- Stall: while out_valid=1 and out_ready=0, out_byte/out_lane/out_last are held stable, and in_word/in_be are ignored.
- Mask=0 word: consumes one handshake cycle, out_valid is never raised, in_ready remains 1.
- Single-bit mask: exactly one byte, out_last=1.
- Reset mid-word: remaining bytes are discarded, next cycle is IDLE with all outputs at reset values.

## Configuration
- SPLIT_SEQ_LSB_FIRST_EN:
  - defined: emission order is lane 0 → lane 3 (LSB byte first); out_last marks the highest enabled lane.
  - undefined: order is lane 3 → lane 0; out_last marks the lowest enabled lane.
- All other behaviour is identical.

## Structure
- Package split_seq_pkg contains:
  - state typedef (IDLE, SEND)
  - constants BYTE_W=8, LANES=4, LANE_W=2
  - next-lane function: (mask, ptr, order) → next enabled lane plus a none-left flag.
- Sub-module: the team's existing combinational splitter is instantiated on the held word register. Its four byte outputs feed the lane mux selected by ptr.

## Test plan
- in_word=0x11223344, in_be=4'hF, out_ready=1 → bytes 0x11,0x22,0x33,0x44 on lanes 3,2,1,0 in cycles N+1..N+4; out_last only with 0x44; in_ready=1 in cycle N+4.
- in_word=0xAABBCCDD, in_be=4'b0101 → 0xBB on lane 2 (out_last=0), then 0xDD on lane 0 (out_last=1). Exactly 2 bytes.
- in_be=4'h0, any word → out_valid stays 0, in_ready=1 in the following cycle, busy never asserted.
- Word 0x11223344, full mask, out_ready low for 3 cycles while 0x22 is presented → 0x22/lane 2 held stable for the whole stall. The sequence completes with no lost or duplicated byte.
- Two full-mask words 0x01020304 then 0x05060708 offered back-to-back, out_ready=1 → 8 consecutive out_valid cycles, 0x01..0x08 in order.
- Reset asserted after the second byte of 0x11223344 → next cycle out_valid=0, busy=0. A fresh 0xCAFEBABE is emitted starting at 0xCA.
- With SPLIT_SEQ_LSB_FIRST_EN defined, the first scenario produces 0x44,0x33,0x22,0x11 on lanes 0..3, with out_last on 0x11.
